// File: rtl/aes_pipeline_ingress_if.sv
// Host-side beat bus and the per-beat output bundle of the AES ingress block.
// The master drives host beats; the slave (the ingress block) returns parsed beats.
interface aes_pipeline_ingress_if;
    logic           i_valid;
    logic           o_ready;
    logic [0:127]   i_data;
    logic           i_last;
    logic           o_valid;
    logic [0:127]   o_cipher_key;
    logic [0:95]    o_iv;
    logic [0:127]   o_instance_size;
    logic [0:127]   o_aad;
    logic [0:127]   o_plain_text;
    logic           o_new_instance;
    logic           o_pt_instance;
    logic           o_error;

    modport master (
        output i_valid, i_data, i_last,
        input  o_ready, o_valid, o_cipher_key, o_iv, o_instance_size,
               o_aad, o_plain_text, o_new_instance, o_pt_instance, o_error
    );

    modport slave (
        input  i_valid, i_data, i_last,
        output o_ready, o_valid, o_cipher_key, o_iv, o_instance_size,
               o_aad, o_plain_text, o_new_instance, o_pt_instance, o_error
    );
endinterface

// File: rtl/aes_pipeline_ingress.sv
// Parses a framed host stream (key, IV, lengths, AAD, PT) into per-block output beats
// carrying the instance header, with tail masking and framing-error detection.
module aes_pipeline_ingress (
    input  logic                   clk,
    input  logic                   rst,
    aes_pipeline_ingress_if.slave  bus
);

    typedef enum logic [2:0] {
        S_KEY,
        S_IV,
        S_LEN,
        S_AAD,
        S_PT,
        S_EMPTY
    } state_t;

    state_t         r_state;
    logic           r_ready;
    logic           r_valid;
    logic [0:127]   r_key;
    logic [0:95]    r_iv;
    logic [63:0]    r_aad_len;
    logic [63:0]    r_pt_len;
    logic [63:0]    r_aad_rem;
    logic [63:0]    r_pt_rem;
    logic [0:127]   r_aad;
    logic [0:127]   r_pt;
    logic           r_first;
    logic           r_new;
    logic           r_pt_inst;
    logic           r_err;

    logic           w_accept;
    logic [63:0]    w_len_aad;
    logic [63:0]    w_len_pt;
    logic           w_aad_final;
    logic           w_pt_final;
    logic [63:0]    w_aad_take;
    logic [63:0]    w_pt_take;
    logic [0:127]   w_aad_mask;
    logic [0:127]   w_pt_mask;

    // Keeps the leading rem bits of a block when fewer than 128 bits remain.
    function automatic logic [0:127] tail_mask(input logic [63:0] rem);
        logic [0:127] m;
        m = '1;
        if (rem < 64'd128) begin
            m = ~({128{1'b1}} >> rem[6:0]);
        end
        return m;
    endfunction

    always_comb begin
        w_accept    = bus.i_valid && r_ready;
        w_len_aad   = bus.i_data[0:63];
        w_len_pt    = bus.i_data[64:127];
        w_aad_final = (r_aad_rem <= 64'd128);
        w_pt_final  = (r_pt_rem <= 64'd128);
        w_aad_take  = (r_aad_rem < 64'd128) ? r_aad_rem : 64'd128;
        w_pt_take   = (r_pt_rem < 64'd128) ? r_pt_rem : 64'd128;
        w_aad_mask  = tail_mask(r_aad_rem);
        w_pt_mask   = tail_mask(r_pt_rem);
    end

    // Single FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_KEY;
            r_ready   <= 1'b0;
            r_valid   <= 1'b0;
            r_key     <= '0;
            r_iv      <= '0;
            r_aad_len <= '0;
            r_pt_len  <= '0;
            r_aad_rem <= '0;
            r_pt_rem  <= '0;
            r_aad     <= '0;
            r_pt      <= '0;
            r_first   <= 1'b0;
            r_new     <= 1'b0;
            r_pt_inst <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_aad     <= '0;
            r_pt      <= '0;
            r_new     <= 1'b0;
            r_pt_inst <= 1'b0;
            r_err     <= 1'b0;

            case (r_state)
                S_KEY: begin
                    if (w_accept) begin
                        r_key <= bus.i_data;
                        if (bus.i_last) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_IV;
                        end
                    end
                end

                S_IV: begin
                    if (w_accept) begin
                        r_iv <= bus.i_data[0:95];
                        if (bus.i_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_KEY;
                        end else begin
                            r_state <= S_LEN;
                        end
                    end
                end

                S_LEN: begin
                    if (w_accept) begin
                        r_aad_len <= w_len_aad;
                        r_pt_len  <= w_len_pt;
                        r_aad_rem <= w_len_aad;
                        r_pt_rem  <= w_len_pt;
                        // An empty instance ends on its length beat and still emits one beat.
                        if (w_len_aad == 64'd0 && w_len_pt == 64'd0) begin
                            r_state <= S_EMPTY;
                            r_ready <= 1'b0;
                            r_valid <= 1'b1;
                            r_new   <= 1'b1;
                            r_err   <= !bus.i_last;
                        end else if (bus.i_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_KEY;
                        end else begin
                            r_first <= 1'b1;
                            r_state <= (w_len_aad != 64'd0) ? S_AAD : S_PT;
                        end
                    end
                end

                S_AAD: begin
                    if (w_accept) begin
                        r_valid   <= 1'b1;
                        r_aad     <= bus.i_data & w_aad_mask;
                        r_new     <= r_first;
                        r_first   <= 1'b0;
                        r_aad_rem <= r_aad_rem - w_aad_take;
                        if (w_aad_final && r_pt_rem != 64'd0) begin
                            if (bus.i_last) begin
                                r_err   <= 1'b1;
                                r_state <= S_KEY;
                            end else begin
                                r_state <= S_PT;
                            end
                        end else if (w_aad_final) begin
                            r_err   <= !bus.i_last;
                            r_state <= S_KEY;
                        end else if (bus.i_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_KEY;
                        end
                    end
                end

                S_PT: begin
                    if (w_accept) begin
                        r_valid   <= 1'b1;
                        r_pt      <= bus.i_data & w_pt_mask;
                        r_pt_inst <= 1'b1;
                        r_new     <= r_first;
                        r_first   <= 1'b0;
                        r_pt_rem  <= r_pt_rem - w_pt_take;
                        if (w_pt_final) begin
                            r_err   <= !bus.i_last;
                            r_state <= S_KEY;
                        end else if (bus.i_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_KEY;
                        end
                    end
                end

                S_EMPTY: begin
                    r_state <= S_KEY;
                end

                default: begin
                    r_state <= S_KEY;
                end
            endcase
        end
    end

    assign bus.o_ready         = r_ready;
    assign bus.o_valid         = r_valid;
    assign bus.o_cipher_key    = r_key;
    assign bus.o_iv            = r_iv;
    assign bus.o_instance_size = {r_aad_len, r_pt_len};
    assign bus.o_aad           = r_aad;
    assign bus.o_plain_text    = r_pt;
    assign bus.o_new_instance  = r_new;
    assign bus.o_pt_instance   = r_pt_inst;
    assign bus.o_error         = r_err;

endmodule

// File: tb/tb_aes_pipeline_ingress.sv
// Scoreboard bench for aes_pipeline_ingress: expected beats are queued as stimulus is
// driven and compared as the block emits them.
module tb_aes_pipeline_ingress;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_pipeline_ingress_if bus ();

    aes_pipeline_ingress dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic           valid;
        logic           err;
        logic           newI;
        logic           ptI;
        logic [0:127]   aad;
        logic [0:127]   pt;
        logic [0:127]   key;
        logic [0:95]    iv;
        logic [0:127]   size;
    } exp_t;

    exp_t           sb[$];
    exp_t           monE;
    int             checks = 0;
    int             errors = 0;
    bit             monEn = 1'b0;
    logic [0:127]   curKey;
    logic [0:95]    curIv;
    logic [0:127]   curSize;

    // Every emitted beat or error pulse is matched against the head of the queue.
    always @(negedge clk) begin
        if (monEn) begin
            if (bus.o_valid === 1'b1 || bus.o_error === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_beat valid=%b error=%b expected none", bus.o_valid, bus.o_error);
                end else begin
                    monE = sb.pop_front();
                    if ({bus.o_valid, bus.o_error, bus.o_new_instance, bus.o_pt_instance} !==
                        {monE.valid, monE.err, monE.newI, monE.ptI}) begin
                        errors++;
                        $display("[TB] FAIL beat_ctrl got v/e/n/p=%b%b%b%b expected %b%b%b%b",
                                 bus.o_valid, bus.o_error, bus.o_new_instance, bus.o_pt_instance,
                                 monE.valid, monE.err, monE.newI, monE.ptI);
                    end
                    checks++;
                    if (bus.o_aad !== monE.aad || bus.o_plain_text !== monE.pt) begin
                        errors++;
                        $display("[TB] FAIL beat_data got aad=%h pt=%h expected aad=%h pt=%h",
                                 bus.o_aad, bus.o_plain_text, monE.aad, monE.pt);
                    end
                    if (monE.valid) begin
                        checks++;
                        if (bus.o_cipher_key !== monE.key || bus.o_iv !== monE.iv ||
                            bus.o_instance_size !== monE.size) begin
                            errors++;
                            $display("[TB] FAIL beat_header got key=%h iv=%h size=%h expected key=%h iv=%h size=%h",
                                     bus.o_cipher_key, bus.o_iv, bus.o_instance_size,
                                     monE.key, monE.iv, monE.size);
                        end
                    end
                end
            end else begin
                checks++;
                if ({bus.o_aad, bus.o_plain_text, bus.o_new_instance, bus.o_pt_instance} !== '0) begin
                    errors++;
                    $display("[TB] FAIL idle_zero got aad=%h pt=%h new=%b pt_inst=%b expected all zero",
                             bus.o_aad, bus.o_plain_text, bus.o_new_instance, bus.o_pt_instance);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic pushBeat(input bit isPt, input logic [0:127] blk, input logic [63:0] rem,
                            input bit newI, input bit err);
        exp_t e;
        logic [0:127] m;
        for (int b = 0; b < 128; b++) begin
            m[b] = (rem >= 64'd128) || (64'(b) < rem);
        end
        e.valid = 1'b1;
        e.err   = err;
        e.newI  = newI;
        e.ptI   = isPt;
        e.aad   = isPt ? '0 : (blk & m);
        e.pt    = isPt ? (blk & m) : '0;
        e.key   = curKey;
        e.iv    = curIv;
        e.size  = curSize;
        sb.push_back(e);
    endtask

    task automatic pushEmpty();
        exp_t e;
        e.valid = 1'b1;
        e.err   = 1'b0;
        e.newI  = 1'b1;
        e.ptI   = 1'b0;
        e.aad   = '0;
        e.pt    = '0;
        e.key   = curKey;
        e.iv    = curIv;
        e.size  = curSize;
        sb.push_back(e);
    endtask

    task automatic pushErrOnly();
        exp_t e;
        e.valid = 1'b0;
        e.err   = 1'b1;
        e.newI  = 1'b0;
        e.ptI   = 1'b0;
        e.aad   = '0;
        e.pt    = '0;
        e.key   = '0;
        e.iv    = '0;
        e.size  = '0;
        sb.push_back(e);
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = '0;
    endtask

    // Holds the beat until o_ready is seen high at an edge; returns the cycles spent.
    task automatic drive_beat(input logic [0:127] d, input bit last, output int cyc);
        bit rdy;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = last;
        cyc = 0;
        rdy = 1'b0;
        while (!rdy && cyc < 64) begin
            @(negedge clk);
            rdy = (bus.o_ready === 1'b1);
            @(posedge clk);
            cyc++;
        end
        #1;
        if (!rdy) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout got no o_ready within %0d cycles expected acceptance", cyc);
        end
    endtask

    task automatic gap(input bit gapped);
        if (gapped) begin
            idle();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic setHeader(input logic [0:127] key, input logic [0:95] iv,
                             input logic [63:0] aadLen, input logic [63:0] ptLen);
        curKey  = key;
        curIv   = iv;
        curSize = {aadLen, ptLen};
    endtask

    task automatic sendHeaders(input logic [0:127] key, input logic [0:95] iv,
                               input logic [63:0] aadLen, input logic [63:0] ptLen,
                               input bit gapped, output int keyCyc);
        int c;
        bit empty;
        empty = (aadLen == 64'd0 && ptLen == 64'd0);
        setHeader(key, iv, aadLen, ptLen);
        drive_beat(key, 1'b0, keyCyc);
        gap(gapped);
        drive_beat({iv, 32'hDEADBEEF}, 1'b0, c);
        gap(gapped);
        if (empty) pushEmpty();
        drive_beat({aadLen, ptLen}, empty, c);
        gap(gapped);
    endtask

    task automatic sendInstance(input logic [0:127] key, input logic [0:95] iv,
                                input logic [63:0] aadLen, input logic [63:0] ptLen,
                                input bit allOnes, input bit gapped, output int keyCyc);
        int c;
        int nA;
        int nP;
        bit first;
        logic [0:127] d;
        nA = int'((aadLen + 64'd127) / 64'd128);
        nP = int'((ptLen + 64'd127) / 64'd128);
        sendHeaders(key, iv, aadLen, ptLen, gapped, keyCyc);
        first = 1'b1;
        for (int i = 0; i < nA; i++) begin
            d = allOnes ? '1 : rnd128();
            pushBeat(1'b0, d, aadLen - 64'(i) * 64'd128, first, 1'b0);
            first = 1'b0;
            drive_beat(d, (nP == 0 && i == nA - 1), c);
            gap(gapped);
        end
        for (int i = 0; i < nP; i++) begin
            d = allOnes ? '1 : rnd128();
            pushBeat(1'b1, d, ptLen - 64'(i) * 64'd128, first, 1'b0);
            first = 1'b0;
            drive_beat(d, (i == nP - 1), c);
            gap(gapped);
        end
    endtask

    task automatic drain(input string name);
        idle();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s_drain got %0d beats outstanding expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_error, bus.o_new_instance, bus.o_pt_instance} !== 5'b0 ||
            {bus.o_aad, bus.o_plain_text, bus.o_cipher_key, bus.o_iv, bus.o_instance_size} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got valid=%b ready=%b error=%b key=%h expected all zero",
                     bus.o_valid, bus.o_ready, bus.o_error, bus.o_cipher_key);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cycle_ready got %b expected 0", bus.o_ready);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready got %b expected 1", bus.o_ready);
        end
        monEn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int kc;
        sendInstance(128'h000102030405060708090A0B0C0D0E0F, 96'hCAFEBABE0011223344556677,
                     64'd128, 64'd256, 1'b0, 1'b0, kc);
        drain("basic");
    endtask

    task automatic test_empty();
        int kc;
        int lowCnt;
        sendInstance(128'h11111111222222223333333344444444, 96'h0123456789ABCDEF01234567,
                     64'd0, 64'd0, 1'b0, 1'b0, kc);
        idle();
        lowCnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_ready !== 1'b1) lowCnt++;
        end
        checks++;
        if (lowCnt != 1) begin
            errors++;
            $display("[TB] FAIL empty_ready_low got %0d cycles expected 1", lowCnt);
        end
        drain("empty");
    endtask

    task automatic test_partial();
        int kc;
        sendInstance(rnd128(), 96'hFEEDFACE0BADF00D12345678, 64'd0, 64'd200, 1'b1, 1'b0, kc);
        drain("partial");
        sendInstance(rnd128(), 96'h0000000100000002AAAA5555, 64'd77, 64'd5, 1'b1, 1'b0, kc);
        drain("partial_aad");
    endtask

    task automatic test_early_last();
        int kc;
        int c;
        logic [0:127] d;
        sendHeaders(rnd128(), 96'h00000000000000000000BEEF, 64'd0, 64'd384, 1'b0, kc);
        d = rnd128();
        pushBeat(1'b1, d, 64'd384, 1'b1, 1'b1);
        drive_beat(d, 1'b1, c);
        sendInstance(rnd128(), 96'h123123123123123123123123, 64'd0, 64'd128, 1'b0, 1'b0, kc);
        checks++;
        if (kc != 1) begin
            errors++;
            $display("[TB] FAIL early_last_key_accept got %0d cycles expected 1", kc);
        end
        drain("early_last");
    endtask

    task automatic test_framing();
        int kc;
        int c;
        logic [0:127] d;
        sendHeaders(rnd128(), 96'h0000FFFF0000FFFF0000FFFF, 64'd0, 64'd128, 1'b0, kc);
        d = rnd128();
        pushBeat(1'b1, d, 64'd128, 1'b1, 1'b1);
        drive_beat(d, 1'b0, c);
        pushErrOnly();
        drive_beat(rnd128(), 1'b1, c);
        sendInstance(rnd128(), 96'h5A5A5A5A5A5A5A5A5A5A5A5A, 64'd256, 64'd0, 1'b0, 1'b0, kc);
        drain("framing");
    endtask

    task automatic test_reset_mid();
        int kc;
        sendHeaders(rnd128(), 96'h777777777777777777777777, 64'd256, 64'd128, 1'b0, kc);
        bus.i_valid = 1'b1;
        bus.i_data  = rnd128();
        bus.i_last  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle();
        @(negedge clk);
        checks++;
        if ({bus.o_valid, bus.o_ready, bus.o_error} !== 3'b0 ||
            {bus.o_aad, bus.o_plain_text, bus.o_cipher_key, bus.o_iv, bus.o_instance_size} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs got valid=%b ready=%b error=%b size=%h expected all zero",
                     bus.o_valid, bus.o_ready, bus.o_error, bus.o_instance_size);
        end
        sendInstance(rnd128(), 96'h999999999999999999999999, 64'd0, 64'd128, 1'b0, 1'b0, kc);
        drain("reset_mid");
    endtask

    task automatic test_gapped();
        int kc;
        sendInstance(rnd128(), 96'hABCDEFABCDEFABCDEFABCDEF, 64'd0, 64'd512, 1'b0, 1'b1, kc);
        drain("gapped");
    endtask

    task automatic test_back_to_back();
        int kc;
        sendInstance(rnd128(), 96'h010101010101010101010101, 64'd128, 64'd128, 1'b0, 1'b0, kc);
        sendInstance(rnd128(), 96'h020202020202020202020202, 64'd0, 64'd256, 1'b0, 1'b0, kc);
        checks++;
        if (kc != 1) begin
            errors++;
            $display("[TB] FAIL back_to_back_key_accept got %0d cycles expected 1", kc);
        end
        drain("back_to_back");
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_empty();
        test_partial();
        test_early_last();
        test_framing();
        test_reset_mid();
        test_gapped();
        test_back_to_back();
        monEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
